// File: rtl/uart_msg_serializer_if.sv
// -----------------------------------------------------------------------------
// uart_msg_serializer_if
// Bundles the two handshakes around the message serializer:
//   controller side : msg_in / msg_req -> msg_ready, plus busy and msg_count
//   UART TX side    : tx_data / tx_valid -> tx_ready
// Modports:
//   slave  - the serializer itself
//   master - whoever drives the controller and UART-TX sides (controller/TX
//            glue or a bench)
// Parameters:
//   MSG_BYTES   - bytes per message (message width MSG_BYTES*8)
//   COUNT_WIDTH - width of the completed-message counter
// -----------------------------------------------------------------------------
interface uart_msg_serializer_if #(
   parameter int MSG_BYTES   = 4,
   parameter int COUNT_WIDTH = 16
);
   logic [MSG_BYTES*8-1:0] msg_in;
   logic                   msg_req;
   logic                   msg_ready;
   logic [7:0]             tx_data;
   logic                   tx_valid;
   logic                   tx_ready;
   logic                   busy;
   logic [COUNT_WIDTH-1:0] msg_count;

   modport slave (
      input  msg_in, msg_req, tx_ready,
      output msg_ready, tx_data, tx_valid, busy, msg_count
   );

   modport master (
      output msg_in, msg_req, tx_ready,
      input  msg_ready, tx_data, tx_valid, busy, msg_count
   );
endinterface

// File: rtl/uart_msg_serializer.sv
// -----------------------------------------------------------------------------
// uart_msg_serializer
// Takes one MSG_BYTES-wide message from the controller (req/ready) and streams
// it LSB byte first to the byte-level UART transmitter (valid/ready).
//
// Ports:
//   clk      - system clock, rising edge
//   n_reset  - asynchronous active-low reset; aborts any message in flight
//   bus      - uart_msg_serializer_if.slave:
//                msg_in/msg_req/msg_ready : message accept handshake
//                tx_data/tx_valid/tx_ready: byte stream to UART TX
//                busy                     : message in flight (~msg_ready)
//                msg_count                : completed messages (wraps)
//
// Optional feature (macro SERIALIZER_CHECKSUM_EN):
//   When defined, a running XOR of the message bytes is appended as one extra
//   byte (state CSUM), so a message is MSG_BYTES+1 bytes on the wire.
//
// All outputs decode only registered state, so there is no combinational path
// from msg_req or tx_ready to any output.
// -----------------------------------------------------------------------------
module uart_msg_serializer #(
   parameter int MSG_BYTES   = 4,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   n_reset,
   uart_msg_serializer_if.slave   bus
);

   localparam int MSG_W = MSG_BYTES * 8;
   localparam int IDX_W = $clog2(MSG_BYTES + 1);

`ifdef SERIALIZER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, CSUM = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

   state_t                 state, state_nxt;
   logic [MSG_W-1:0]       shift_q;
   logic [IDX_W-1:0]       idx_q;
   logic [COUNT_WIDTH-1:0] count_q;
   logic                   accept;
   logic                   last_byte;
   logic                   msg_ready;
   logic                   tx_valid;
   logic [7:0]             tx_data;
`ifdef SERIALIZER_CHECKSUM_EN
   logic [7:0]             csum_q;
`endif

   assign accept    = (state == IDLE) && bus.msg_req;
   assign last_byte = (idx_q == IDX_W'(MSG_BYTES - 1));

   // State register
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.msg_req) state_nxt = SEND;
         SEND: begin
            if (bus.tx_ready && last_byte) begin
`ifdef SERIALIZER_CHECKSUM_EN
               state_nxt = CSUM;
`else
               state_nxt = IDLE;
`endif
            end
         end
`ifdef SERIALIZER_CHECKSUM_EN
         CSUM: if (bus.tx_ready) state_nxt = IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode (state and datapath registers only)
   always_comb begin
      msg_ready = (state == IDLE);
      tx_valid  = (state != IDLE);
      tx_data   = shift_q[7:0];
`ifdef SERIALIZER_CHECKSUM_EN
      if (state == CSUM) tx_data = csum_q;
`endif
   end

   // Datapath: shift register, byte index, checksum, message counter.
   // In SEND/CSUM tx_valid is high, so tx_ready alone marks a handshake.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         shift_q <= '0;
         idx_q   <= '0;
         count_q <= '0;
`ifdef SERIALIZER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else if (accept) begin
         shift_q <= bus.msg_in;
         idx_q   <= '0;
`ifdef SERIALIZER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else if (state == SEND && bus.tx_ready) begin
         shift_q <= {8'd0, shift_q[MSG_W-1:8]};
         idx_q   <= idx_q + IDX_W'(1);
`ifdef SERIALIZER_CHECKSUM_EN
         csum_q  <= csum_q ^ shift_q[7:0];
`else
         if (last_byte) count_q <= count_q + COUNT_WIDTH'(1);
`endif
      end
`ifdef SERIALIZER_CHECKSUM_EN
      else if (state == CSUM && bus.tx_ready) begin
         count_q <= count_q + COUNT_WIDTH'(1);
      end
`endif
   end

   assign bus.msg_ready = msg_ready;
   assign bus.busy      = ~msg_ready;
   assign bus.tx_valid  = tx_valid;
   assign bus.tx_data   = tx_data;
   assign bus.msg_count = count_q;

endmodule

// File: tb/tb_uart_msg_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_msg_serializer
// Table of message vectors sent back to back, plus hand-written sequences for
// reset values and reset in the middle of a message. A second instance with a
// 2-bit counter runs in lockstep so counter wrap is seen within a few messages.
// Build with +define+SERIALIZER_CHECKSUM_EN to expect the appended XOR byte.
// -----------------------------------------------------------------------------
module tb_uart_msg_serializer;

`ifdef SERIALIZER_CHECKSUM_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif

   logic clk;
   logic n_reset;
   int   n_checks;
   int   n_fail;

   uart_msg_serializer_if #(.MSG_BYTES(4), .COUNT_WIDTH(16)) bus  ();
   uart_msg_serializer_if #(.MSG_BYTES(4), .COUNT_WIDTH(2))  bus2 ();

   uart_msg_serializer #(.MSG_BYTES(4), .COUNT_WIDTH(16)) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .bus     (bus.slave)
   );

   uart_msg_serializer #(.MSG_BYTES(4), .COUNT_WIDTH(2)) dut2 (
      .clk     (clk),
      .n_reset (n_reset),
      .bus     (bus2.slave)
   );

   assign bus2.msg_in   = bus.msg_in;
   assign bus2.msg_req  = bus.msg_req;
   assign bus2.tx_ready = bus.tx_ready;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]     msg;
      int              stall_idx;   // byte held with tx_ready low (-1: none)
      int              stall_len;
      int              req_idx;     // byte during which a stray req is pulsed
      logic [31:0]     alt;         // msg_in value presented with the stray req
      logic [4:0][7:0] b;           // expected wire bytes, b[4] = checksum
      logic [15:0]     cnt;         // msg_count after this message
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called with msg_ready expected high; returns one cycle after the final
   // handshake, which is the idle cycle where the next req may be issued.
   task automatic send_vec(input vec_t v, input int k);
      string s;
      s = $sformatf("v%0d", k);
      check({s, "_ready"}, {31'd0, bus.msg_ready}, 32'd1);
      bus.msg_in   = v.msg;
      bus.msg_req  = 1'b1;
      bus.tx_ready = 1'b1;
      tick();
      bus.msg_req = 1'b0;
      check({s, "_busy"}, {31'd0, bus.busy}, 32'd1);
      for (int i = 0; i < NB; i++) begin
         check($sformatf("%s_valid%0d", s, i), {31'd0, bus.tx_valid}, 32'd1);
         check($sformatf("%s_data%0d", s, i), {24'd0, bus.tx_data}, {24'd0, v.b[i]});
         if (i == v.req_idx) begin
            bus.msg_req = 1'b1;
            bus.msg_in  = v.alt;
         end
         if (i == v.stall_idx) begin
            bus.tx_ready = 1'b0;
            for (int j = 0; j < v.stall_len; j++) begin
               tick();
               bus.msg_req = 1'b0;
               check($sformatf("%s_stv%0d_%0d", s, i, j), {31'd0, bus.tx_valid}, 32'd1);
               check($sformatf("%s_std%0d_%0d", s, i, j), {24'd0, bus.tx_data}, {24'd0, v.b[i]});
            end
            bus.tx_ready = 1'b1;
         end
         tick();
         bus.msg_req = 1'b0;
      end
      check({s, "_end_valid"}, {31'd0, bus.tx_valid}, 32'd0);
      check({s, "_end_ready"}, {31'd0, bus.msg_ready}, 32'd1);
      check({s, "_end_busy"}, {31'd0, bus.busy}, 32'd0);
      check({s, "_count"}, {16'd0, bus.msg_count}, {16'd0, v.cnt});
      check({s, "_count2"}, {30'd0, bus2.msg_count}, {30'd0, v.cnt[1:0]});
   endtask

   initial begin
      vec_t a5;
      n_checks = 0;
      n_fail   = 0;
      n_reset      = 1'b0;
      bus.msg_in   = 32'd0;
      bus.msg_req  = 1'b0;
      bus.tx_ready = 1'b0;

      vecs[0] = '{msg: 32'h12345678, stall_idx: -1, stall_len: 0, req_idx: -1, alt: 32'd0,
                  b: {8'h08, 8'h12, 8'h34, 8'h56, 8'h78}, cnt: 16'd1};
      vecs[1] = '{msg: 32'h12345678, stall_idx: 2, stall_len: 5, req_idx: -1, alt: 32'd0,
                  b: {8'h08, 8'h12, 8'h34, 8'h56, 8'h78}, cnt: 16'd2};
      vecs[2] = '{msg: 32'h12345678, stall_idx: -1, stall_len: 0, req_idx: 1, alt: 32'hAABBCCDD,
                  b: {8'h08, 8'h12, 8'h34, 8'h56, 8'h78}, cnt: 16'd3};
      vecs[3] = '{msg: 32'hAABBCCDD, stall_idx: -1, stall_len: 0, req_idx: -1, alt: 32'd0,
                  b: {8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD}, cnt: 16'd4};
      vecs[4] = '{msg: 32'h01020380, stall_idx: 3, stall_len: 3, req_idx: -1, alt: 32'd0,
                  b: {8'h80, 8'h01, 8'h02, 8'h03, 8'h80}, cnt: 16'd5};
      vecs[5] = '{msg: 32'hFFFFFFFF, stall_idx: 0, stall_len: 2, req_idx: 2, alt: 32'h0,
                  b: {8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, cnt: 16'd6};

      // Reset values
      tick();
      tick();
      check("rst_ready", {31'd0, bus.msg_ready}, 32'd1);
      check("rst_busy",  {31'd0, bus.busy}, 32'd0);
      check("rst_valid", {31'd0, bus.tx_valid}, 32'd0);
      check("rst_data",  {24'd0, bus.tx_data}, 32'd0);
      check("rst_count", {16'd0, bus.msg_count}, 32'd0);
      n_reset = 1'b1;
      tick();

      // Back-to-back table; dut2's 2-bit counter wraps at the 4th message
      for (int k = 0; k < 6; k++) send_vec(vecs[k], k);

      // Reset in the middle of a message
      bus.msg_in  = 32'h12345678;
      bus.msg_req = 1'b1;
      tick();
      bus.msg_req = 1'b0;
      check("mr_b0", {24'd0, bus.tx_data}, 32'h78);
      tick();
      check("mr_b1", {24'd0, bus.tx_data}, 32'h56);
      tick();
      check("mr_b2", {24'd0, bus.tx_data}, 32'h34);
      n_reset = 1'b0;
      #1;
      check("mr_valid_async", {31'd0, bus.tx_valid}, 32'd0);
      check("mr_count", {16'd0, bus.msg_count}, 32'd0);
      check("mr_data", {24'd0, bus.tx_data}, 32'd0);
      tick();
      n_reset = 1'b1;
      tick();
      check("mr_ready", {31'd0, bus.msg_ready}, 32'd1);
      check("mr_valid", {31'd0, bus.tx_valid}, 32'd0);

      a5 = '{msg: 32'h0000A5A5, stall_idx: -1, stall_len: 0, req_idx: -1, alt: 32'd0,
             b: {8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5}, cnt: 16'd1};
      send_vec(a5, 6);

      // Idle with no request stays idle
      tick();
      tick();
      check("idle_valid", {31'd0, bus.tx_valid}, 32'd0);
      check("idle_count", {16'd0, bus.msg_count}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_msg_serializer.md
Name: uart_msg_serializer

Overview:
- Transmit-side counterpart of the controller's outgoing message path.
- Accepts one complete fixed-width UART message from the controller through a req/ready handshake.
- Emits the message LSB-byte-first as a stream of 8-bit words to the byte-level UART transmitter through a valid/ready handshake.
- Sits between the controller's uart_out_msg/uart_out_req/uart_out_ready and the UART TX core.

Parameters:
MSG_BYTES, 4, number of bytes per message; message width = MSG_BYTES*8; legal range 2..16
COUNT_WIDTH, 16, width of the sent-message counter

Ports:
clk  input  1  system clock; all logic on rising edge
n_reset  input  1  asynchronous active-low reset
msg_in  input  MSG_BYTES*8  message from controller; header in byte 0 (LSBs)
msg_req  input  1  controller requests transmission of msg_in
msg_ready  output  1  serializer can accept a message this cycle
tx_data  output  8  byte to UART transmitter
tx_valid  output  1  tx_data is valid
tx_ready  input  1  UART transmitter accepts tx_data this cycle
busy  output  1  message in flight (inverse of msg_ready)
msg_count  output  COUNT_WIDTH  number of messages fully transmitted

Behaviour:
- Reset (n_reset low, asynchronous): state=IDLE, msg_ready=1, busy=0, tx_valid=0, tx_data=0, msg_count=0, shift register=0, byte index=0.
- All outputs are registered. No combinational path from msg_req or tx_ready to any output.
- States: IDLE, SEND, plus CSUM when SERIALIZER_CHECKSUM_EN is defined.
- IDLE:
  - msg_ready=1, tx_valid=0.
  - msg_req=1 -> latch msg_in into the shift register, byte index=0, go to SEND.
  - On the next cycle: msg_ready=0, tx_valid=1, tx_data=msg_in[7:0].
  - Latency from accepted req to first tx_valid: 1 cycle.
- SEND:
  - tx_valid=1. tx_data and tx_valid are held stable while tx_ready=0; stalling is unbounded.
  - Handshake (tx_valid & tx_ready): shift register right by 8, byte index+1; tx_data becomes the next byte on the following cycle.
  - Handshake on byte index MSG_BYTES-1:
    - Without checksum: go to IDLE, tx_valid=0, msg_ready=1 next cycle, msg_count increments.
    - With checksum: go to CSUM.
- Back-to-back messages: one idle cycle with msg_ready=1 between messages (no same-cycle reload). Maximum throughput is MSG_BYTES+1 cycles per message when tx_ready is held high.
- msg_req while msg_ready=0 is ignored: message not latched, no error raised. The controller only asserts req when ready is high.
- msg_in is sampled only on the accepting cycle. Later changes to msg_in have no effect on the message in flight.
- msg_count wraps from 2^COUNT_WIDTH-1 to 0 and increments exactly once per completed message.
- Reset asserted mid-message: the transfer is aborted immediately, tx_valid drops asynchronously, and the partial message is discarded (not resumed).
- Byte index width = clog2(MSG_BYTES+1).

Optional Feature:
- Macro: SERIALIZER_CHECKSUM_EN.
- Defined:
  - A running XOR of all transmitted message bytes is kept; it clears on message accept.
  - After the last message byte handshake, state CSUM drives tx_data=XOR checksum with tx_valid=1.
  - On that handshake: go to IDLE and msg_count increments.
  - A message is MSG_BYTES+1 bytes on the wire.
- Undefined: no checksum register, no CSUM state, exactly MSG_BYTES bytes per message.

Test Plan:
- Reset, then msg_in=0x12345678 with msg_req for 1 cycle and tx_ready held high -> tx_valid from the next cycle; bytes 0x78,0x56,0x34,0x12 on consecutive cycles; msg_count=1; msg_ready=1 one cycle after the last byte.
- Same message with tx_ready low for 5 cycles during byte 2 -> tx_data held at 0x34 with tx_valid=1 throughout the stall; no byte duplicated or skipped; sequence otherwise unchanged.
- Second msg_req=0xAABBCCDD pulsed while busy, with msg_in changed mid-transfer -> first message still sends 0x78,0x56,0x34,0x12; second request ignored; msg_count=1.
- Two messages back-to-back, each req issued in the first cycle msg_ready=1 -> 8 bytes in correct order; exactly one idle cycle between messages; msg_count=2.
- n_reset pulsed low after 2 bytes of 0x12345678 -> tx_valid=0 immediately, msg_count=0, msg_ready=1 after release; next message 0x0000A5A5 sends 0xA5,0xA5,0x00,0x00.
- With SERIALIZER_CHECKSUM_EN, send 0x12345678 -> bytes 0x78,0x56,0x34,0x12,0x08; msg_count increments only after 0x08 is accepted. Preload msg_count=0xFFFF (force) then send one message -> msg_count=0x0000.
